// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and FSM state encodings for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request, MTHI/MTLO write and HI/LO result bundle of the multiply/divide unit
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, wr_hi, wr_lo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - operand magnitudes on entry and result sign correction on exit
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [2*WIDTH-1:0] res,
  output logic [WIDTH-1:0]   fix_hi,
  output logic [WIDTH-1:0]   fix_lo
);
  logic [2*WIDTH-1:0] res_neg;
  logic [WIDTH-1:0]   hi_neg;
  logic [WIDTH-1:0]   lo_neg;

  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    res_neg = -res;
    hi_neg  = -res[2*WIDTH-1:WIDTH];
    lo_neg  = -res[WIDTH-1:0];
    fix_hi  = res[2*WIDTH-1:WIDTH];
    fix_lo  = res[WIDTH-1:0];
    // Products negate as one wide value; quotient and remainder carry independent signs.
    if (is_div) begin
      if (neg_r) fix_hi = hi_neg;
      if (neg_q) fix_lo = lo_neg;
    end else if (neg_q) begin
      fix_hi = res_neg[2*WIDTH-1:WIDTH];
      fix_lo = res_neg[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;
  logic               done_r;
  logic               dbz_out;
  logic               accept;
  logic               last_step;
  logic               op_div;
  logic               b_zero;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_signed (op_is_signed(bus.op)),
    .a         (bus.a),
    .b         (bus.b),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .is_div    (is_div),
    .neg_q     (neg_q),
    .neg_r     (neg_r),
    .res       (acc),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  assign op_div = op_is_div(bus.op);
  assign b_zero = (bus.b == '0);
  assign accept = (state == S_IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign last_step = (cnt == CW'(WIDTH - 1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  // Restoring divide: acc holds {remainder, dividend/quotient}, divisor sits in mplier.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mplier};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (op_div && b_zero) ? S_FIX : S_CALC;
      S_CALC: begin
        if (bus.flush)     state_next = S_IDLE;
        else if (last_step) state_next = S_FIX;
      end
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz     <= 1'b0;
      done_r  <= 1'b0;
      dbz_out <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      dbz_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wr_hi) hi_r <= bus.wdata;
          if (bus.wr_lo) lo_r <= bus.wdata;
          if (accept) begin
            is_div <= op_div;
            neg_q  <= op_is_signed(bus.op) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= op_is_signed(bus.op) && bus.a[WIDTH-1];
            dbz    <= op_div && b_zero;
            cnt    <= '0;
            mplier <= mag_b;
            if (op_div) begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              mcand <= '0;
            end else begin
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, mag_a};
            end
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
              else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            done_r  <= 1'b1;
            dbz_out <= dbz;
            if (!dbz) begin
              hi_r <= fix_hi;
              lo_r <= fix_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_out;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - vector table, corner sequences and randomized ops against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t         vecs[7];
  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0] mag;
    int steps;
`endif
    if (op[1]) return (b == '0) ? 1 : W + 1;
`ifdef MULDIV_EARLY_OUT_EN
    mag   = (op == OP_MULT && b[W-1]) ? -b : b;
    steps = 1;
    for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
    return steps + 1;
`else
    return W + 1;
`endif
  endfunction

  // Updates the model HI/LO as the architecture defines each op.
  task automatic ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic dbz);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    dbz = 1'b0;
    if (op == OP_MULT) begin
      p = sa * sb;
      {m_hi, m_lo} = p;
    end else if (op == OP_MULTU) begin
      p = ua * ub;
      {m_hi, m_lo} = p;
    end else if (b == '0) begin
      dbz = 1'b1;
    end else if (op == OP_DIV) begin
      p = sa / sb;
      m_lo = p[W-1:0];
      p = sa % sb;
      m_hi = p[W-1:0];
    end else begin
      p = ua / ub;
      m_lo = p[W-1:0];
      p = ua % ub;
      m_hi = p[W-1:0];
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic write_reg(input logic is_hi, input logic [W-1:0] d);
    @(negedge clk);
    bus.wr_hi = is_hi;
    bus.wr_lo = !is_hi;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    if (is_hi) m_hi = d;
    else       m_lo = d;
  endtask

  task automatic run_and_check(input string name, input logic [1:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    logic dbz;
    int   n;
    ref_op(op, a, b, dbz);
    launch(op, a, b);
    check({name, " busy"}, bus.busy, 1);
    wait_done(n);
    check({name, " lat"}, n, ref_lat(op, b));
    check({name, " hi"}, bus.hi, m_hi);
    check({name, " lo"}, bus.lo, m_lo);
    check({name, " dbz"}, bus.div_by_zero, dbz);
    check({name, " idle"}, bus.busy, 0);
  endtask

  initial begin
    int   n;
    int   done_seen;
    logic [1:0]   op;
    logic [W-1:0] a, b;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset dbz", bus.div_by_zero, 0);
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n);
      check($sformatf("vec%0d lat", i), n, ref_lat(vecs[i].op, vecs[i].b));
      check($sformatf("vec%0d hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d lo", i), bus.lo, vecs[i].lo);
      check($sformatf("vec%0d dbz", i), bus.div_by_zero, 0);
      m_hi = vecs[i].hi;
      m_lo = vecs[i].lo;
    end

    // Divide by zero leaves preloaded HI/LO alone and finishes one edge after the start.
    write_reg(1'b1, 32'h1234);
    write_reg(1'b0, 32'h5678);
    check("mthi", bus.hi, 32'h1234);
    check("mtlo", bus.lo, 32'h5678);
    launch(OP_DIV, 32'd5, 32'd0);
    wait_done(n);
    check("dbz lat", n, 1);
    check("dbz flag", bus.div_by_zero, 1);
    check("dbz hi", bus.hi, 32'h1234);
    check("dbz lo", bus.lo, 32'h5678);

    // Flush at E10: no done, HI/LO untouched.
    launch(OP_MULTU, 32'h12345678, 32'h9ABCDEF1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush busy", bus.busy, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("flush no done", done_seen, 0);
    check("flush hi", bus.hi, 32'h1234);
    check("flush lo", bus.lo, 32'h5678);

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULTU;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush+start busy", bus.busy, 0);

    // Reset mid-op clears everything.
    launch(OP_MULTU, 32'h12345678, 32'h9ABCDEF1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst busy", bus.busy, 0);
    check("rst hi", bus.hi, 0);
    check("rst lo", bus.lo, 0);
    m_hi = '0;
    m_lo = '0;

    // Start and MTLO while busy are both ignored.
    ref_op(OP_MULTU, 32'd3, 32'hFFFFFFFF, bus.wr_hi);
    launch(OP_MULTU, 32'd3, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.b     = '0;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_hi = 1'b0;
    wait_done(n);
    check("busy-ign lat", n, W + 1 - 3);
    check("busy-ign hi", bus.hi, 32'h2);
    check("busy-ign lo", bus.lo, 32'hFFFFFFFD);
    check("busy-ign dbz", bus.div_by_zero, 0);

    // A write on the start edge lands, then the result overwrites it.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.wr_hi = 1'b1;
    bus.wdata = 32'hAAAA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    check("wr@start hi", bus.hi, 32'hAAAA);
    wait_done(n);
    check("wr@start lat", n, ref_lat(OP_MULTU, 32'd3));
    check("wr@start res hi", bus.hi, 0);
    check("wr@start res lo", bus.lo, 32'd6);

    // Multiply latency with a short multiplier.
    launch(OP_MULTU, 32'd7, 32'd3);
    wait_done(n);
`ifdef MULDIV_EARLY_OUT_EN
    check("short mult lat", n, 3);
`else
    check("short mult lat", n, 33);
`endif
    check("short mult lo", bus.lo, 32'd21);
    m_hi = bus.hi;
    m_lo = 32'd21;
    m_hi = '0;

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        2:       b = $urandom;
        default: b = -W'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        write_reg(1'b1, $urandom);
        write_reg(1'b0, $urandom);
      end
      run_and_check($sformatf("rnd%0d", i), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
